// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-producer FIFOs drained one entry per cycle
// by a round-robin scheduler onto a registered broadcast port.
module cdb_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int DEPTH   = 2,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_value,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [SRC_W-1:0]          cdb_src,
  output logic                      busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [TAG_W-1:0]  r_tag_mem [NUM_SRC][DEPTH];
  logic [DATA_W-1:0] r_val_mem [NUM_SRC][DEPTH];
  logic [PW-1:0]     r_wr_ptr  [NUM_SRC];
  logic [PW-1:0]     r_rd_ptr  [NUM_SRC];
  logic [CW-1:0]     r_count   [NUM_SRC];
  logic [SRC_W-1:0]  r_rr_ptr;

  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_nonempty;
  logic               w_grant_vld;
  logic [SRC_W-1:0]   w_grant;
  logic [SRC_W-1:0]   w_rr_next;
  logic [SRC_W:0]     w_scan;

  // Ready looks only at the pre-edge count: a full FIFO refuses even when it pops.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_nonempty[i] = (r_count[i] != '0);
      src_ready[i]  = rdy_in & (r_count[i] != CW'(DEPTH));
      w_push[i]     = src_valid[i] & src_ready[i];
    end
  end

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_scan      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
      if (w_scan >= (SRC_W+1)'(NUM_SRC)) w_scan = w_scan - (SRC_W+1)'(NUM_SRC);
      if (!w_grant_vld && w_nonempty[w_scan[SRC_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_scan[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_pop[i] = w_grant_vld && (w_grant == SRC_W'(i));
    end
    w_rr_next = (w_grant == SRC_W'(NUM_SRC - 1)) ? '0 : w_grant + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && !clear) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_push[i]) begin
          r_tag_mem[i][r_wr_ptr[i]] <= src_tag[i*TAG_W +: TAG_W];
          r_val_mem[i][r_wr_ptr[i]] <= src_value[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Clear empties the FIFOs but keeps rr_ptr so fairness survives a flush.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
      r_rr_ptr  <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      cdb_valid <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        if (w_push[i] && !w_pop[i])      r_count[i] <= r_count[i] + 1'b1;
        else if (w_pop[i] && !w_push[i]) r_count[i] <= r_count[i] - 1'b1;
      end
      cdb_valid <= w_grant_vld;
      if (w_grant_vld) begin
        cdb_tag   <= r_tag_mem[w_grant][r_rd_ptr[w_grant]];
        cdb_value <= r_val_mem[w_grant][r_rd_ptr[w_grant]];
        cdb_src   <= w_grant;
        r_rr_ptr  <= w_rr_next;
      end
    end
  end

  assign busy = (|w_nonempty) | cdb_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdb_arbiter;

  localparam int NUM_SRC = 2;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 5;
  localparam int DEPTH   = 2;
  localparam int SRC_W   = 1;

  typedef logic [TAG_W+DATA_W-1:0] ent_t;

  logic                      clk_in = 1'b0;
  logic                      rst_in;
  logic                      rdy_in;
  logic                      clear;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DATA_W-1:0] src_value;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_value;
  logic [SRC_W-1:0]          cdb_src;
  logic                      busy;

  cdb_arbiter #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .src_valid(src_valid), .src_tag(src_tag), .src_value(src_value),
    .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_src(cdb_src), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard / model ----------------
  ent_t             exp_q [NUM_SRC][$];
  int               m_rr;
  int               m_g;
  int               m_sz [NUM_SRC];
  ent_t             m_ent;
  logic             m_cdb_valid;
  logic [TAG_W-1:0] m_cdb_tag;
  logic [DATA_W-1:0] m_cdb_value;
  logic [SRC_W-1:0] m_cdb_src;
  int               n_checks = 0;
  int               n_fail   = 0;
  bit               check_en = 1'b0;
  logic [TAG_W-1:0] tag_ctr  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NUM_SRC-1:0] model_ready();
    logic [NUM_SRC-1:0] r;
    for (int i = 0; i < NUM_SRC; i++) r[i] = rdy_in && (exp_q[i].size() < DEPTH);
    return r;
  endfunction

  function automatic logic model_busy();
    logic b = m_cdb_valid;
    for (int i = 0; i < NUM_SRC; i++) if (exp_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  // Model advances on the same edge as the DUT, using the inputs held since posedge+1.
  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_SRC; i++) exp_q[i].delete();
      m_rr = 0; m_cdb_valid = 1'b0; m_cdb_tag = '0; m_cdb_value = '0; m_cdb_src = '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_SRC; i++) exp_q[i].delete();
      m_cdb_valid = 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < NUM_SRC; i++) m_sz[i] = exp_q[i].size();
      m_g = -1;
      for (int k = 0; k < NUM_SRC; k++)
        if (m_g < 0 && m_sz[(m_rr + k) % NUM_SRC] > 0) m_g = (m_rr + k) % NUM_SRC;
      if (m_g >= 0) begin
        m_ent       = exp_q[m_g].pop_front();
        m_cdb_valid = 1'b1;
        m_cdb_tag   = m_ent[TAG_W+DATA_W-1:DATA_W];
        m_cdb_value = m_ent[DATA_W-1:0];
        m_cdb_src   = SRC_W'(m_g);
        m_rr        = (m_g + 1) % NUM_SRC;
      end else begin
        m_cdb_valid = 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++)
        if (src_valid[i] && m_sz[i] < DEPTH)
          exp_q[i].push_back({src_tag[i*TAG_W +: TAG_W], src_value[i*DATA_W +: DATA_W]});
    end
  end

  // Compare process: outputs sampled mid-cycle against the model.
  always @(negedge clk_in) begin
    if (check_en) begin
      chk("cdb_valid", 64'(cdb_valid), 64'(m_cdb_valid));
      chk("cdb_tag",   64'(cdb_tag),   64'(m_cdb_tag));
      chk("cdb_value", 64'(cdb_value), 64'(m_cdb_value));
      chk("cdb_src",   64'(cdb_src),   64'(m_cdb_src));
      chk("src_ready", 64'(src_ready), 64'(model_ready()));
      chk("busy",      64'(busy),      64'(model_busy()));
      for (int i = 0; i < NUM_SRC; i++)
        if (!rst_in && src_valid[i]) chk("protocol", 64'(src_ready[i]), 64'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_push(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    src_valid[i] = 1'b1;
    src_tag[i*TAG_W +: TAG_W] = t;
    src_value[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic push_ready_srcs();
    src_valid = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (rdy_in && exp_q[i].size() < DEPTH) begin
        set_push(i, tag_ctr, $urandom & 32'h7FFF_FFFF);
        tag_ctr = tag_ctr + 1'b1;
      end
  endtask

  task automatic rand_cycle(input int p_stall, input int p_clear, input int p_rst);
    rst_in = ($urandom_range(999) < p_rst);
    rdy_in = ($urandom_range(99) >= p_stall);
    clear  = ($urandom_range(99) < p_clear);
    src_valid = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (rdy_in && exp_q[i].size() < DEPTH && $urandom_range(1) == 1) begin
        set_push(i, tag_ctr, $urandom & 32'h7FFF_FFFF);
        tag_ctr = tag_ctr + 1'b1;
      end
    tick();
    rst_in = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic idle(input int n);
    src_valid = '0; rdy_in = 1'b1; clear = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // ---------------- directed + random stimulus ----------------
  int  prev_src;
  bit  started;
  int  guard;

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    src_valid = '0; src_tag = '0; src_value = '0;
    tick(); tick();
    check_en = 1'b1;
    chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    chk("reset_src_ready", 64'(src_ready), 64'b11);

    // Single entry: two-edge latency to the CDB.
    rst_in = 1'b0;
    set_push(0, 5'd3, 32'h1234_5678);
    tick();
    src_valid = '0;
    tick();
    chk("lat_valid", 64'(cdb_valid), 64'd1);
    chk("lat_tag",   64'(cdb_tag),   64'd3);
    chk("lat_value", 64'(cdb_value), 64'h1234_5678);
    chk("lat_src",   64'(cdb_src),   64'd0);
    tick();
    chk("lat_valid_drop", 64'(cdb_valid), 64'd0);
    chk("lat_busy_drop",  64'(busy),      64'd0);

    // Both sources streaming: strict alternation, no gaps.
    started = 1'b0; prev_src = 0;
    for (int c = 0; c < 16; c++) begin
      push_ready_srcs();
      tick();
      if (cdb_valid) begin
        if (started) chk("alt_src", 64'(cdb_src), 64'(prev_src ^ 1));
        started = 1'b1;
        prev_src = int'(cdb_src);
      end else if (started) begin
        chk("no_gap", 64'(cdb_valid), 64'd1);
      end
    end
    idle(6);

    // src1 alone, three back-to-back with draining: never back-pressured.
    for (int c = 0; c < 3; c++) begin
      chk("src1_ready_stream", 64'(src_ready[1]), 64'd1);
      src_valid = '0;
      set_push(1, tag_ctr, 32'h0000_1000 + c);
      tag_ctr = tag_ctr + 1'b1;
      tick();
    end
    idle(4);
    // Both push: src0 repeatedly reaches full while being popped.
    for (int c = 0; c < 10; c++) begin
      push_ready_srcs();
      tick();
    end
    idle(6);

    // Clear with data pending; the push on the clear edge must vanish.
    push_ready_srcs(); tick();
    push_ready_srcs(); tick();
    chk("pre_clear_busy", 64'(busy), 64'd1);
    src_valid = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (exp_q[i].size() < DEPTH && src_valid == '0) set_push(i, 5'h1F, 32'hDEAD_BEEF);
    clear = 1'b1;
    tick();
    clear = 1'b0; src_valid = '0;
    chk("clear_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("clear_src_ready", 64'(src_ready), 64'b11);
    chk("clear_busy",      64'(busy),      64'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("clear_leak", 64'(cdb_valid && cdb_value == 32'hDEAD_BEEF), 64'd0);
    end

    // Mid-stream stall of three cycles.
    for (int c = 0; c < 3; c++) begin push_ready_srcs(); tick(); end
    src_valid = '0; rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_ready", 64'(src_ready), 64'd0);
      chk("stall_valid", 64'(cdb_valid), 64'd1);
    end
    rdy_in = 1'b1;
    for (int c = 0; c < 4; c++) begin push_ready_srcs(); tick(); end

    // Reset while busy, right after a grant to source 0 (rr_ptr = 1 before reset).
    guard = 0;
    while (!(m_cdb_valid && m_cdb_src == 0 && (exp_q[0].size() + exp_q[1].size()) > 0) && guard < 12) begin
      push_ready_srcs(); tick(); guard++;
    end
    chk("pre_rst_state_reached", 64'(guard < 12), 64'd1);
    src_valid = '0; rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_tag",   64'(cdb_tag),   64'd0);
    chk("rst_cdb_value", 64'(cdb_value), 64'd0);
    chk("rst_cdb_src",   64'(cdb_src),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'b11);
    set_push(0, 5'd7, 32'h0000_0A0A);
    set_push(1, 5'd9, 32'h0000_0B0B);
    tick();
    src_valid = '0;
    tick();
    chk("rst_first_grant_src", 64'(cdb_src),   64'd0);
    chk("rst_first_grant_tag", 64'(cdb_tag),   64'd7);
    tick();
    chk("rst_second_grant_src", 64'(cdb_src),  64'd1);
    chk("rst_second_grant_tag", 64'(cdb_tag),  64'd9);
    idle(3);

    // Randomized traffic with stalls, flushes and occasional resets.
    for (int c = 0; c < 3000; c++) rand_cycle(10, 3, 5);
    idle(8);
    chk("final_busy", 64'(busy), 64'd0);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
